// File: rtl/polyphase_fir_decimator.sv
// Decimate-by-DEC FIR: samples go into a circular history buffer, and every DEC-th accept
// starts a serial multiply-accumulate over all TAPS coefficients, one tap per cycle.
module polyphase_fir_decimator #(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int TAPS = 32,
    parameter int DEC  = 4,
    parameter int OW   = DW + CW + $clog2(TAPS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DW-1:0]    in_data,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic signed [CW-1:0]    coef_din,
    output logic                    out_valid,
    output logic signed [OW-1:0]    out_data
);
    localparam int AW = $clog2(TAPS);
    localparam int PW = $clog2(DEC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                    r_state;
    logic signed [DW-1:0]      r_x [TAPS];
    logic signed [CW-1:0]      r_h [TAPS];
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_newest;
    logic [AW-1:0]             r_k;
    logic [PW-1:0]             r_phase;
    logic signed [OW-1:0]      r_acc;
    logic                      r_out_valid;
    logic signed [OW-1:0]      r_out_data;

    logic [AW-1:0]             w_idx;
    logic signed [DW+CW-1:0]   w_prod;
    logic signed [OW-1:0]      w_prod_ext;
    logic                      w_addr_ok;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Table index must stay inside 0..TAPS-1 even when TAPS is not a power of two.
    assign w_addr_ok = ({1'b0, coef_addr} < (AW+1)'(TAPS));

    // Sample index (newest - k) mod TAPS, wrapped explicitly for non-power-of-two TAPS.
    always_comb begin
        w_idx = '0;
        if (r_newest >= r_k) begin
            w_idx = r_newest - r_k;
        end else begin
            w_idx = r_newest + AW'(TAPS) - r_k;
        end
    end

    // Full-precision product, sign-extended to the accumulator width.
    always_comb begin
        w_prod     = r_h[r_k] * r_x[w_idx];
        w_prod_ext = {{(OW-DW-CW){w_prod[DW+CW-1]}}, w_prod};
    end

    // Control FSM, sample/coefficient storage and MAC datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= {AW{1'b0}};
            r_newest    <= {AW{1'b0}};
            r_k         <= {AW{1'b0}};
            r_phase     <= {PW{1'b0}};
            r_acc       <= {OW{1'b0}};
            r_out_valid <= 1'b0;
            r_out_data  <= {OW{1'b0}};
            for (int i = 0; i < TAPS; i++) begin
                r_x[i] <= {DW{1'b0}};
                r_h[i] <= {CW{1'b0}};
            end
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (coef_we && w_addr_ok) begin
                        r_h[coef_addr] <= coef_din;
                    end
                    if (in_valid) begin
                        r_x[r_wr_ptr] <= in_data;
                        r_newest      <= r_wr_ptr;
                        if (r_wr_ptr == AW'(TAPS-1)) begin
                            r_wr_ptr <= {AW{1'b0}};
                        end else begin
                            r_wr_ptr <= r_wr_ptr + AW'(1);
                        end
                        if (r_phase == PW'(DEC-1)) begin
                            r_phase <= {PW{1'b0}};
                            r_acc   <= {OW{1'b0}};
                            r_k     <= {AW{1'b0}};
                            r_state <= S_MAC;
                        end else begin
                            r_phase <= r_phase + PW'(1);
                        end
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_k == AW'(TAPS-1)) begin
                        r_state <= S_OUT;
                    end else begin
                        r_k <= r_k + AW'(1);
                    end
                end
                S_OUT: begin
                    r_out_data  <= r_acc;
                    r_out_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_polyphase_fir_decimator.sv
// Randomised and directed bench for polyphase_fir_decimator against a queue-based FIR model.
module tb_polyphase_fir_decimator;
    localparam int DW = 16, CW = 16, TAPS = 32, DEC = 4, AW = 5, OW = 37;
    localparam longint BIG = 64'sd34359738368;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 coef_we = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic [AW-1:0]        coef_addr = '0;
    logic signed [CW-1:0] coef_din = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic signed [OW-1:0] out_data;

    int n_chk = 0, n_fail = 0, cyc = 0;
    bit chk_en = 1'b0;

    // model state: coefficient table, newest-first history, busy countdown
    int     mh [TAPS];
    int     hist [$];
    int     m_busy, m_cnt;
    longint m_pend, m_odata;
    bit     m_ovalid;

    longint obs [$];
    int     ov_cyc [$];
    int     lo_q [$];
    int     acc_q [$];
    int     lo_cnt = 0, acc_cnt = 0;

    polyphase_fir_decimator #(.DW(DW), .CW(CW), .TAPS(TAPS), .DEC(DEC), .OW(OW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_din(coef_din), .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) mh[i] = 0;
        hist.delete();
        for (int i = 0; i < TAPS; i++) hist.push_back(0);
        m_busy = 0; m_cnt = 0; m_pend = 0; m_odata = 0; m_ovalid = 1'b0;
    endfunction

    function automatic void model_update();
        longint s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_ovalid = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_ovalid = 1'b1;
                m_odata  = m_pend;
            end
        end else begin
            if (coef_we) mh[coef_addr] = int'(coef_din);
            if (in_valid) begin
                hist.push_front(int'(in_data));
                void'(hist.pop_back());
                m_cnt++;
                if (m_cnt == DEC) begin
                    m_cnt = 0;
                    s = 0;
                    for (int k = 0; k < TAPS; k++) s += longint'(mh[k]) * longint'(hist[k]);
                    m_pend = s;
                    m_busy = TAPS + 1;
                end
            end
        end
    endfunction

    // Per-cycle comparison of the DUT against the model, plus output/handshake logging.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", longint'(in_ready), longint'(m_busy == 0));
            check("out_valid", longint'(out_valid), longint'(m_ovalid));
            check("out_data", out_data, m_odata);
            if (out_valid) begin
                obs.push_back(out_data);
                ov_cyc.push_back(cyc);
                lo_q.push_back(lo_cnt);
                acc_q.push_back(acc_cnt);
                lo_cnt = 0;
                acc_cnt = 0;
            end
            if (!in_ready) lo_cnt++;
            if (in_valid && in_ready) acc_cnt++;
        end
    end

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic wr_coef(input int a, input int v);
        coef_we = 1'b1;
        coef_addr = a[AW-1:0];
        coef_din = v[CW-1:0];
        cycle();
        coef_we = 1'b0;
    endtask

    task automatic send(input int x);
        int  t;
        bit  was;
        t = 0;
        in_valid = 1'b1;
        in_data  = x[DW-1:0];
        forever begin
            was = (m_busy == 0);
            cycle();
            if (was) break;
            t++;
            if (t > 200) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: got no accept after %0d cycles required accept", t);
                break;
            end
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        coef_we = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int r, a;
        model_reset();
        repeat (3) cycle();
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", out_data, 0);

        // impulse response with h[k] = k+1
        for (int k = 0; k < TAPS; k++) wr_coef(k, k + 1);
        obs.delete();
        send(1);
        for (int i = 0; i < 35; i++) send(0);
        idle(TAPS + 5);
        check("imp_count", obs.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < obs.size()) check("imp_value", obs[i], (i < 8) ? 4 * (i + 1) : 0);

        // DC with in_valid held high: buffer wrap and throughput
        do_reset();
        for (int k = 0; k < TAPS; k++) wr_coef(k, 1);
        obs.delete(); ov_cyc.delete(); lo_q.delete(); acc_q.delete();
        for (int i = 0; i < 40; i++) send(100);
        idle(TAPS + 5);
        check("dc_count", obs.size(), 10);
        for (int i = 0; i < 10; i++)
            if (i < obs.size()) check("dc_value", obs[i], ((i < 8) ? 4 * (i + 1) : 32) * 100);
        for (int i = 1; i < 10; i++) begin
            if (i < ov_cyc.size()) begin
                check("bp_period", ov_cyc[i] - ov_cyc[i-1], 37);
                check("bp_ready_low", lo_q[i], 33);
                check("bp_accepts", acc_q[i], 4);
            end
        end

        // extremes, with a coefficient write attempted mid-MAC
        do_reset();
        for (int k = 0; k < TAPS; k++) wr_coef(k, -32768);
        obs.delete();
        for (int i = 0; i < 36; i++) send(-32768);
        in_valid = 1'b0;
        coef_we = 1'b1; coef_addr = '0; coef_din = '0;
        repeat (5) cycle();
        idle(TAPS + 5);
        check("ext_count", obs.size(), 9);
        if (obs.size() >= 9) begin
            check("ext_full", obs[7], BIG);
            check("ext_mac_we", obs[8], BIG);
        end

        // reset in the middle of a MAC aborts the output
        do_reset();
        for (int k = 0; k < TAPS; k++) begin
            r = $urandom;
            wr_coef(k, r);
        end
        for (int i = 0; i < 4; i++) begin
            r = $urandom;
            send(r);
        end
        in_valid = 1'b0;
        repeat (9) cycle();
        #2;
        rst_n = 1'b0;
        model_reset();
        obs.delete();
        cycle();
        cycle();
        rst_n = 1'b1;
        check("abort_in_ready", longint'(in_ready), 1);
        check("abort_out_valid", longint'(out_valid), 0);
        check("abort_out_data", out_data, 0);
        idle(TAPS + 5);
        check("abort_no_output", obs.size(), 0);

        // reload coefficients, then random traffic with stray coefficient writes
        for (int k = 0; k < TAPS; k++) begin
            r = $urandom;
            wr_coef(k, r);
        end
        for (int i = 0; i < 1500; i++) begin
            r = $urandom;
            a = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = r[DW-1:0];
            coef_we   = ($urandom_range(0, 15) == 0);
            coef_addr = a[AW-1:0];
            coef_din  = r[DW+CW-1:DW];
            cycle();
        end
        idle(TAPS + 5);
        check("rand_outputs_seen", longint'(obs.size() > 10), 1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
